servo_pulse_decoder: RTL and testbench

//  Receive side of the hobby-servo PWM link: measures the high time of a 50 Hz servo pulse train on a

---
 rtl/servo_pulse_decoder_pkg.sv | 22 ++
 rtl/servo_pulse_decoder_sync_edge_detect.sv | 34 +++
 rtl/servo_pulse_decoder.sv | 179 +++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pulse_decoder_pkg.sv
// rtl/servo_pulse_decoder_pkg.sv - servo link state encodings and default timing constants
// Shared by the servo pulse decoder and the servo PWM generator.
package servo_pulse_decoder_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        QUANT     = 2'd2,
        WAIT_NEXT = 2'd3
    } servo_state_e;

    // Defaults assume the 50 MHz board clock.
    localparam int SERVO_CW        = 21;
    localparam int SERVO_POS_W     = 4;
    localparam int SERVO_MIN_PULSE = 25000;
    localparam int SERVO_MAX_PULSE = 125000;
    localparam int SERVO_STEP      = 10000;
    localparam int SERVO_FRAME_MIN = 900000;
    localparam int SERVO_FRAME_MAX = 1100000;
    localparam int SERVO_TIMEOUT   = 2000000;

endpackage

// File: rtl/servo_pulse_decoder_sync_edge_detect.sv
// rtl/servo_pulse_decoder_sync_edge_detect.sv - two-flop synchroniser with rise/fall strobes
// Edge strobes are held off until the pipeline holds real input samples after reset.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [2:0] fill_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'b000;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    // A line already high at reset release must not look like a rise.
    assign rise_o = fill_q[2] & sync_q & ~prev_q;
    assign fall_o = fill_q[2] & ~sync_q & prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - measures servo pulse high time, quantises it to a position index
// Also checks rise-to-rise frame period and flags a lost signal after a long idle line.
module servo_pulse_decoder
    import servo_pulse_decoder_pkg::*;
#(
    parameter int CW        = SERVO_CW,
    parameter int POS_W     = SERVO_POS_W,
    parameter int MIN_PULSE = SERVO_MIN_PULSE,
    parameter int MAX_PULSE = SERVO_MAX_PULSE,
    parameter int STEP      = SERVO_STEP,
    parameter int FRAME_MIN = SERVO_FRAME_MIN,
    parameter int FRAME_MAX = SERVO_FRAME_MAX,
    parameter int TIMEOUT   = SERVO_TIMEOUT
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             pwm_in,
    output logic [CW-1:0]    pulse_width,
    output logic [POS_W-1:0] position,
    output logic             pos_valid,
    output logic             err_width,
    output logic             err_frame,
    output logic             signal_lost
);

    localparam logic [CW-1:0]    CNT_MAX   = '1;
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    STEP_C    = CW'(STEP);
    localparam logic [CW-1:0]    TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW:0]      MEAS_ONE  = (CW+1)'(1);
    localparam logic [CW:0]      MIN_W     = (CW+1)'(MIN_PULSE);
    localparam logic [CW:0]      MAX_W     = (CW+1)'(MAX_PULSE);
    localparam logic [CW:0]      FMIN_W    = (CW+1)'(FRAME_MIN);
    localparam logic [CW:0]      FMAX_W    = (CW+1)'(FRAME_MAX);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET_N),
        .d_i    (pwm_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    servo_state_e     state_q;
    logic [CW-1:0]    high_cnt_q;
    logic [CW-1:0]    high_cnt_d;
    logic [CW-1:0]    period_cnt_q;
    logic [CW-1:0]    period_cnt_d;
    logic [CW-1:0]    idle_cnt_q;
    logic [CW-1:0]    idle_cnt_d;
    logic [CW-1:0]    rem_q;
    logic [POS_W-1:0] cnt_q;
    logic             rise_pending_q;
    logic [CW-1:0]    pulse_width_q;
    logic [POS_W-1:0] position_q;
    logic             pos_valid_q;
    logic             err_width_q;
    logic             err_frame_q;
    logic             signal_lost_q;
    logic [CW:0]      high_meas;
    logic [CW:0]      period_meas;
    logic             width_ok;
    logic             period_ok;

    // Counters lag the line by one clock, so +1 includes the edge cycle itself.
    assign high_meas   = {1'b0, high_cnt_q} + MEAS_ONE;
    assign period_meas = {1'b0, period_cnt_q} + MEAS_ONE;
    assign width_ok    = (high_meas >= MIN_W) && (high_meas <= MAX_W);
    assign period_ok   = (period_meas >= FMIN_W) && (period_meas <= FMAX_W);

    always_comb begin
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        if (rise) begin
            high_cnt_d = '0;
        end else if (state_q == MEAS_HIGH && high_cnt_q != CNT_MAX) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
        end
        if (rise) begin
            period_cnt_d = '0;
        end else if (period_cnt_q != CNT_MAX) begin
            period_cnt_d = period_cnt_q + CNT_ONE;
        end
        if (rise || fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= WAIT_RISE;
            high_cnt_q     <= '0;
            period_cnt_q   <= '0;
            idle_cnt_q     <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            rise_pending_q <= 1'b0;
            pulse_width_q  <= '0;
            position_q     <= '0;
            pos_valid_q    <= 1'b0;
            err_width_q    <= 1'b0;
            err_frame_q    <= 1'b0;
            signal_lost_q  <= 1'b0;
        end else begin
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            pos_valid_q  <= 1'b0;
            err_width_q  <= 1'b0;
            err_frame_q  <= 1'b0;
            // Equality fires once per idle stretch; the saturated counter then sits above it.
            if (idle_cnt_q == TIMEOUT_C) begin
                signal_lost_q  <= 1'b1;
                rise_pending_q <= 1'b0;
                state_q        <= WAIT_RISE;
            end else begin
                case (state_q)
                    WAIT_RISE: begin
                        if (rise) begin
                            state_q <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            if (width_ok) begin
                                pulse_width_q <= high_meas[CW-1:0];
                                rem_q         <= CW'(high_meas - MIN_W);
                                cnt_q         <= '0;
                                state_q       <= QUANT;
                            end else begin
                                err_width_q <= 1'b1;
                                state_q     <= WAIT_NEXT;
                            end
                        end
                    end
                    QUANT: begin
                        if (rise) begin
                            rise_pending_q <= 1'b1;
                        end
                        if (rem_q >= STEP_C) begin
                            rem_q <= rem_q - STEP_C;
                            cnt_q <= cnt_q + POS_ONE;
                        end else begin
                            position_q    <= cnt_q;
                            pos_valid_q   <= 1'b1;
                            signal_lost_q <= 1'b0;
                            state_q       <= WAIT_NEXT;
                        end
                    end
                    WAIT_NEXT: begin
                        if (rise || rise_pending_q) begin
                            rise_pending_q <= 1'b0;
                            if (!period_ok) begin
                                err_frame_q <= 1'b1;
                            end
                            state_q <= MEAS_HIGH;
                        end
                    end
                    default: state_q <= WAIT_RISE;
                endcase
            end
        end
    end

    assign pulse_width = pulse_width_q;
    assign position    = position_q;
    assign pos_valid   = pos_valid_q;
    assign err_width   = err_width_q;
    assign err_frame   = err_frame_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - self-checking bench for servo_pulse_decoder at 1/1000 time scale
module tb_servo_pulse_decoder;

    localparam int CW    = 12;
    localparam int POS_W = 4;
    localparam int MIN_P = 25;
    localparam int MAX_P = 125;
    localparam int STEP  = 10;
    localparam int FMIN  = 900;
    localparam int FMAX  = 1100;
    localparam int TOUT  = 2000;
    localparam int LAT   = 3;

    logic             CLOCK_50 = 1'b0;
    logic             RESET_N  = 1'b1;
    logic             pwm_in   = 1'b0;
    logic [CW-1:0]    pulse_width;
    logic [POS_W-1:0] position;
    logic             pos_valid;
    logic             err_width;
    logic             err_frame;
    logic             signal_lost;

    servo_pulse_decoder #(
        .CW(CW), .POS_W(POS_W), .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P), .STEP(STEP),
        .FRAME_MIN(FMIN), .FRAME_MAX(FMAX), .TIMEOUT(TOUT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .pwm_in      (pwm_in),
        .pulse_width (pulse_width),
        .position    (position),
        .pos_valid   (pos_valid),
        .err_width   (err_width),
        .err_frame   (err_frame),
        .signal_lost (signal_lost)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Expected output events keyed by the cycle at which they become visible.
    int ev_pw[int];
    int ev_pos[int];
    bit ev_ew[int];
    bit ev_ef[int];
    bit ev_lost[int];
    int m_pw, m_pos;
    bit m_lost;

    int last_edge, last_rise, rise_idx, last_fall;
    bit fresh, measuring;
    int pv_cnt = 0, ew_cnt = 0, ef_cnt = 0, last_pv_cyc = 0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(bit v, int e);
        int h, p, pos;
        if (e - last_edge <= TOUT + 1) begin
            ev_lost.delete(last_edge + LAT + 1 + TOUT);
        end else begin
            fresh     = 1'b1;
            measuring = 1'b0;
        end
        last_edge = e;
        ev_lost[e + LAT + 1 + TOUT] = 1'b1;
        if (v) begin
            if (!fresh) begin
                p = e - last_rise;
                if (p < FMIN || p > FMAX) ev_ef[e + LAT] = 1'b1;
            end
            fresh     = 1'b0;
            measuring = 1'b1;
            last_rise = e;
            rise_idx  = e;
        end else begin
            last_fall = e;
            if (measuring) begin
                measuring = 1'b0;
                h = e - rise_idx;
                if (h >= MIN_P && h <= MAX_P) begin
                    pos = (h - MIN_P) / STEP;
                    ev_pw[e + LAT] = h;
                    ev_pos[e + LAT + 1 + pos] = pos;
                end else begin
                    ev_ew[e + LAT] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        ev_pw.delete();
        ev_pos.delete();
        ev_ew.delete();
        ev_ef.delete();
        ev_lost.delete();
        m_pw      = 0;
        m_pos     = 0;
        m_lost    = 1'b0;
        measuring = 1'b0;
        fresh     = 1'b1;
    endtask

    task automatic release_reset();
        RESET_N   = 1'b1;
        last_edge = cyc - LAT;
        ev_lost[last_edge + LAT + 1 + TOUT] = 1'b1;
    endtask

    task automatic hold(bit v, int n);
        if (v != pwm_in) model_edge(v, cyc);
        pwm_in = v;
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic frame(int h, int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    initial begin : compare
        bit e_pv, e_ew, e_ef;
        forever begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            if (chk_en) begin
                if (ev_pw.exists(cyc)) m_pw = ev_pw[cyc];
                e_pv = ev_pos.exists(cyc);
                if (e_pv) begin
                    m_pos  = ev_pos[cyc];
                    m_lost = 1'b0;
                end
                if (ev_lost.exists(cyc)) m_lost = 1'b1;
                e_ew = ev_ew.exists(cyc);
                e_ef = ev_ef.exists(cyc);
                chk("pulse_width", int'(pulse_width), m_pw);
                chk("position", int'(position), m_pos);
                chk("pos_valid", int'(pos_valid), int'(e_pv));
                chk("err_width", int'(err_width), int'(e_ew));
                chk("err_frame", int'(err_frame), int'(e_ef));
                chk("signal_lost", int'(signal_lost), int'(m_lost));
            end
            if (pos_valid) begin
                pv_cnt++;
                last_pv_cyc = cyc;
            end
            if (err_width) ew_cnt++;
            if (err_frame) ef_cnt++;
        end
    end

    initial begin
        #3 RESET_N = 1'b0;
        model_reset();
        #1;
        chk("rst_pulse_width", int'(pulse_width), 0);
        chk("rst_signal_lost", int'(signal_lost), 0);
        repeat (3) @(posedge CLOCK_50);
        #2;
        release_reset();
        chk_en = 1'b1;
        hold(1'b0, 20);

        frame(25, 1000);
        chk("lit_pw_25", int'(pulse_width), 25);
        chk("lit_pos_0", int'(position), 0);
        chk("lit_quant_lat_pos0", last_pv_cyc - last_fall, 4);
        frame(125, 1000);
        chk("lit_pos_10", int'(position), 10);
        chk("lit_quant_lat_pos10", last_pv_cyc - last_fall, 14);
        frame(54, 1000);
        chk("lit_pos_floor_2", int'(position), 2);
        chk("lit_pw_54", int'(pulse_width), 54);
        chk("lit_pv_count", pv_cnt, 3);

        frame(24, 1000);
        frame(126, 1000);
        chk("lit_pos_kept", int'(position), 2);
        chk("lit_pw_kept", int'(pulse_width), 54);
        chk("lit_err_width_count", ew_cnt, 2);

        frame(50, 800);
        frame(50, 1200);
        frame(50, 900);
        frame(50, 1100);
        frame(50, 1000);
        hold(1'b1, 40);
        hold(1'b0, 2100);
        chk("lit_err_frame_count", ef_cnt, 2);
        chk("lit_lost_set", int'(signal_lost), 1);
        chk("lit_pos_after_40", int'(position), 1);

        frame(60, 1000);
        chk("lit_lost_cleared", int'(signal_lost), 0);
        chk("lit_pos_3", int'(position), 3);
        frame(60, 1000);

        hold(1'b1, 30);
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("midrst_pulse_width", int'(pulse_width), 0);
        chk("midrst_position", int'(position), 0);
        chk("midrst_pos_valid", int'(pos_valid), 0);
        chk("midrst_err_width", int'(err_width), 0);
        chk("midrst_err_frame", int'(err_frame), 0);
        repeat (4) @(posedge CLOCK_50);
        #2;
        release_reset();
        hold(1'b1, 20);
        hold(1'b0, 900);
        frame(75, 1000);
        chk("lit_pos_5_after_rst", int'(position), 5);
        chk("lit_pw_75_after_rst", int'(pulse_width), 75);
        chk("lit_err_frame_total", ef_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
